// File: rtl/conv_mc_engine_pkg.sv
// Shared types and size helpers for the multi-channel convolution engine.
// Holds the FSM state type and the output-size / tap-count formulas.
package conv_mc_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Floor division: trailing rows/columns that cannot hold a full window are skipped.
    function automatic int out_size(input int i_size, input int k_size, input int stride);
        return (i_size - k_size) / stride + 1;
    endfunction

    function automatic int tap_count(input int i_channels, input int k_size);
        return i_channels * k_size * k_size;
    endfunction

endpackage

// File: rtl/conv_mc_engine_if.sv
// Start/status handshake and the three BRAM ports of the convolution engine.
// The master modport is the engine side; slave is the BRAM/controller side.
interface conv_mc_engine_if #(
    parameter int I_BIT_WIDTH = 8,
    parameter int O_BIT_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16
);
    logic                   conv_en;
    logic                   conv_busy;
    logic                   conv_done;
    logic [I_BIT_WIDTH-1:0] input_bram_douta;
    logic                   input_bram_ena;
    logic [ADDR_WIDTH-1:0]  input_bram_addra;
    logic [I_BIT_WIDTH-1:0] weights_bram_douta;
    logic                   weights_bram_ena;
    logic [ADDR_WIDTH-1:0]  weights_bram_addra;
    logic [O_BIT_WIDTH-1:0] result_bram_dina;
    logic                   result_bram_ena;
    logic                   result_bram_wea;
    logic [ADDR_WIDTH-1:0]  result_bram_addra;

    modport master (
        input  conv_en, input_bram_douta, weights_bram_douta,
        output conv_busy, conv_done,
        output input_bram_ena, input_bram_addra,
        output weights_bram_ena, weights_bram_addra,
        output result_bram_dina, result_bram_ena, result_bram_wea, result_bram_addra
    );

    modport slave (
        output conv_en, input_bram_douta, weights_bram_douta,
        input  conv_busy, conv_done,
        input  input_bram_ena, input_bram_addra,
        input  weights_bram_ena, weights_bram_addra,
        input  result_bram_dina, result_bram_ena, result_bram_wea, result_bram_addra
    );
endinterface

// File: rtl/conv_mc_engine_addr_gen.sv
// Nested oc/oy/ox pixel counters and ic/ky/kx tap counters with the BRAM
// address arithmetic and first/last flags used by the engine FSM.
module conv_mc_engine_addr_gen
    import conv_mc_engine_pkg::*;
#(
    parameter int I_SIZE     = 24,
    parameter int I_CHANNELS = 1,
    parameter int K_CHANNELS = 16,
    parameter int K_SIZE     = 3,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tap_step,
    input  logic                  pix_step,
    output logic [ADDR_WIDTH-1:0] input_addr,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic [ADDR_WIDTH-1:0] result_addr,
    output logic                  first_tap,
    output logic                  last_tap,
    output logic                  last_pixel
);
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t IS    = addr_t'(I_SIZE);
    localparam addr_t IC    = addr_t'(I_CHANNELS);
    localparam addr_t KS    = addr_t'(K_SIZE);
    localparam addr_t ST    = addr_t'(STRIDE);
    localparam addr_t OS    = addr_t'(out_size(I_SIZE, K_SIZE, STRIDE));
    localparam addr_t KS_M1 = addr_t'(K_SIZE - 1);
    localparam addr_t IC_M1 = addr_t'(I_CHANNELS - 1);
    localparam addr_t KC_M1 = addr_t'(K_CHANNELS - 1);
    localparam addr_t OS_M1 = addr_t'(out_size(I_SIZE, K_SIZE, STRIDE) - 1);

    addr_t oc, oy, ox, ic, ky, kx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oc <= '0;
            oy <= '0;
            ox <= '0;
            ic <= '0;
            ky <= '0;
            kx <= '0;
        end else begin
            if (tap_step) begin
                if (kx == KS_M1) begin
                    kx <= '0;
                    if (ky == KS_M1) begin
                        ky <= '0;
                        ic <= (ic == IC_M1) ? '0 : ic + 1'b1;
                    end else begin
                        ky <= ky + 1'b1;
                    end
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            if (pix_step) begin
                if (ox == OS_M1) begin
                    ox <= '0;
                    if (oy == OS_M1) begin
                        oy <= '0;
                        oc <= (oc == KC_M1) ? '0 : oc + 1'b1;
                    end else begin
                        oy <= oy + 1'b1;
                    end
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end

    assign input_addr  = ic * IS * IS + (oy * ST + ky) * IS + ox * ST + kx;
    assign weight_addr = ((oc * IC + ic) * KS + ky) * KS + kx;
    assign result_addr = oc * OS * OS + oy * OS + ox;

    assign first_tap  = (ic == '0) && (ky == '0) && (kx == '0);
    assign last_tap   = (ic == IC_M1) && (ky == KS_M1) && (kx == KS_M1);
    assign last_pixel = (oc == KC_M1) && (oy == OS_M1) && (ox == OS_M1);

endmodule

// File: rtl/conv_mc_engine.sv
// Strided multi-channel 2-D convolution engine: one MAC tap per cycle, requantise, saturate, write.
// Define CONV_RELU_EN to clamp negative shifted accumulators to zero before saturation.
module conv_mc_engine
    import conv_mc_engine_pkg::*;
#(
    parameter int I_BIT_WIDTH = 8,
    parameter int O_BIT_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int I_SIZE      = 24,
    parameter int I_CHANNELS  = 1,
    parameter int K_CHANNELS  = 16,
    parameter int K_SIZE      = 3,
    parameter int STRIDE      = 1,
    parameter int SHIFT       = 0,
    parameter int ADDR_WIDTH  = 16
) (
    input logic              clk,
    input logic              rstn,
    conv_mc_engine_if.master bus
);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - O_BIT_WIDTH + 1){1'b0}}, {(O_BIT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - O_BIT_WIDTH + 1){1'b1}}, {(O_BIT_WIDTH - 1){1'b0}}};

    state_t state, state_next;
    logic tap_step, pix_step, rd_en, wr_en;
    logic first_tap, last_tap, last_pixel;
    logic data_valid, data_first;
    logic [ADDR_WIDTH-1:0] input_addr, weight_addr, result_addr;
    logic signed [ACC_WIDTH-1:0] acc, pix_ext, wgt_ext, product, shifted, rectified;
    logic [O_BIT_WIDTH-1:0] result_word;

    conv_mc_engine_addr_gen #(
        .I_SIZE    (I_SIZE),
        .I_CHANNELS(I_CHANNELS),
        .K_CHANNELS(K_CHANNELS),
        .K_SIZE    (K_SIZE),
        .STRIDE    (STRIDE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .tap_step   (tap_step),
        .pix_step   (pix_step),
        .input_addr (input_addr),
        .weight_addr(weight_addr),
        .result_addr(result_addr),
        .first_tap  (first_tap),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    // BRAM data lags the issued tap by one cycle, so the load/add decision is pipelined with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            data_valid <= 1'b0;
            data_first <= 1'b0;
            acc        <= '0;
        end else begin
            state      <= state_next;
            data_valid <= tap_step;
            data_first <= tap_step && first_tap;
            if (data_valid) begin
                acc <= data_first ? product : acc + product;
            end
        end
    end

    always_comb begin
        state_next = state;
        tap_step   = 1'b0;
        pix_step   = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        unique case (state)
            S_IDLE:  if (bus.conv_en) state_next = S_RUN;
            S_RUN: begin
                tap_step = 1'b1;
                rd_en    = 1'b1;
                if (last_tap) state_next = S_DRAIN;
            end
            S_DRAIN: state_next = S_WRITE;
            S_WRITE: begin
                pix_step   = 1'b1;
                wr_en      = 1'b1;
                state_next = last_pixel ? S_DONE : S_RUN;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign pix_ext = ACC_WIDTH'($signed(bus.input_bram_douta[I_BIT_WIDTH-1:0]));
    assign wgt_ext = ACC_WIDTH'($signed(bus.weights_bram_douta[I_BIT_WIDTH-1:0]));
    assign product = pix_ext * wgt_ext;
    assign shifted = acc >>> SHIFT;

`ifdef CONV_RELU_EN
    assign rectified = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
    assign rectified = shifted;
`endif

    always_comb begin
        result_word = rectified[O_BIT_WIDTH-1:0];
        if (rectified > SAT_MAX) begin
            result_word = SAT_MAX[O_BIT_WIDTH-1:0];
        end else if (rectified < SAT_MIN) begin
            result_word = SAT_MIN[O_BIT_WIDTH-1:0];
        end
    end

    assign bus.conv_busy          = (state != S_IDLE);
    assign bus.conv_done          = (state == S_DONE);
    assign bus.input_bram_ena     = rd_en;
    assign bus.input_bram_addra   = rd_en ? input_addr : '0;
    assign bus.weights_bram_ena   = rd_en;
    assign bus.weights_bram_addra = rd_en ? weight_addr : '0;
    assign bus.result_bram_ena    = wr_en;
    assign bus.result_bram_wea    = wr_en;
    assign bus.result_bram_addra  = wr_en ? result_addr : '0;
    assign bus.result_bram_dina   = wr_en ? result_word : '0;

endmodule

// File: tb/tb_conv_mc_engine.sv
// Scoreboard bench for conv_mc_engine: a plain-arithmetic convolution model queues the
// expected result writes per run; a negedge monitor pops and compares every BRAM write.
`timescale 1ns/1ps
module tb_conv_mc_engine;
    localparam int IBW  = 8;
    localparam int OBW  = 16;
    localparam int ACCW = 32;
    localparam int ISZ  = 6;
    localparam int ICH  = 2;
    localparam int KCH  = 2;
    localparam int KSZ  = 3;
    localparam int STR  = 2;
    localparam int SHF  = 2;
    localparam int AW   = 16;

    localparam int OSZ        = (ISZ - KSZ) / STR + 1;
    localparam int TAPS       = ICH * KSZ * KSZ;
    localparam int PIX        = KCH * OSZ * OSZ;
    localparam int RUN_CYCLES = PIX * (TAPS + 2) + 1;
    localparam int REACH      = (OSZ - 1) * STR + KSZ;
    localparam int IN_WORDS   = ICH * ISZ * ISZ;
    localparam int WT_WORDS   = KCH * ICH * KSZ * KSZ;

    typedef struct {
        int addr;
        int data;
    } result_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    int img [ICH][ISZ][ISZ];
    int wt  [KCH][ICH][KSZ][KSZ];
    logic [IBW-1:0] in_mem [IN_WORDS];
    logic [IBW-1:0] wt_mem [WT_WORDS];
    result_t exp_q[$];
    result_t mon_exp;

    int checks = 0;
    int errors = 0;
    int rd_count, bad_reads, second_pixel_addr;
    int rd_a, mon_data;

    conv_mc_engine_if #(.I_BIT_WIDTH(IBW), .O_BIT_WIDTH(OBW), .ADDR_WIDTH(AW)) bus ();

    conv_mc_engine #(
        .I_BIT_WIDTH(IBW),
        .O_BIT_WIDTH(OBW),
        .ACC_WIDTH  (ACCW),
        .I_SIZE     (ISZ),
        .I_CHANNELS (ICH),
        .K_CHANNELS (KCH),
        .K_SIZE     (KSZ),
        .STRIDE     (STR),
        .SHIFT      (SHF),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port BRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.input_bram_ena && int'(bus.input_bram_addra) < IN_WORDS)
            bus.input_bram_douta <= in_mem[int'(bus.input_bram_addra)];
        if (bus.weights_bram_ena && int'(bus.weights_bram_addra) < WT_WORDS)
            bus.weights_bram_douta <= wt_mem[int'(bus.weights_bram_addra)];
    end

    // Watch the input read stream: windows must stay inside the reachable region.
    always @(negedge clk) begin
        if (rstn && bus.input_bram_ena) begin
            rd_a = int'(bus.input_bram_addra);
            if (rd_a >= IN_WORDS || (rd_a % ISZ) >= REACH || ((rd_a / ISZ) % ISZ) >= REACH)
                bad_reads++;
            if (rd_count == TAPS) second_pixel_addr = rd_a;
            rd_count++;
        end
    end

    always @(negedge clk) begin
        if (rstn && bus.result_bram_ena) begin
            checks++;
            mon_data = int'($signed(bus.result_bram_dina));
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d", bus.result_bram_addra, mon_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(bus.result_bram_addra) != mon_exp.addr || mon_data != mon_exp.data
                    || !bus.result_bram_wea) begin
                    errors++;
                    $display("FAIL result_write got addr=%0d data=%0d wea=%0b expected addr=%0d data=%0d",
                             bus.result_bram_addra, mon_data, bus.result_bram_wea,
                             mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    function automatic int requant(input longint sum);
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) << (OBW - 1)) - 1;
        lo = -(longint'(1) << (OBW - 1));
        v  = sum >>> SHF;
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return int'(v);
    endfunction

    task automatic load_pattern(input int pattern);
        int v;
        for (int ic = 0; ic < ICH; ic++)
            for (int y = 0; y < ISZ; y++)
                for (int x = 0; x < ISZ; x++) begin
                    case (pattern)
                        0:       v = 1;
                        1:       v = ic + 1;
                        2, 3:    v = 127;
                        4:       v = int'($urandom_range(0, 255)) - 128;
                        default: v = int'($urandom_range(0, 15)) - 8;
                    endcase
                    img[ic][y][x] = v;
                    in_mem[ic * ISZ * ISZ + y * ISZ + x] = IBW'(v);
                end
        for (int oc = 0; oc < KCH; oc++)
            for (int ic = 0; ic < ICH; ic++)
                for (int ky = 0; ky < KSZ; ky++)
                    for (int kx = 0; kx < KSZ; kx++) begin
                        case (pattern)
                            0:       v = 1;
                            1:       v = oc + 1;
                            2:       v = 127;
                            3:       v = -128;
                            4:       v = int'($urandom_range(0, 255)) - 128;
                            default: v = int'($urandom_range(0, 15)) - 8;
                        endcase
                        wt[oc][ic][ky][kx] = v;
                        wt_mem[((oc * ICH + ic) * KSZ + ky) * KSZ + kx] = IBW'(v);
                    end
    endtask

    task automatic push_expected();
        longint sum;
        result_t r;
        for (int oc = 0; oc < KCH; oc++)
            for (int oy = 0; oy < OSZ; oy++)
                for (int ox = 0; ox < OSZ; ox++) begin
                    sum = 0;
                    for (int ic = 0; ic < ICH; ic++)
                        for (int ky = 0; ky < KSZ; ky++)
                            for (int kx = 0; kx < KSZ; kx++)
                                sum += longint'(img[ic][oy * STR + ky][ox * STR + kx])
                                     * longint'(wt[oc][ic][ky][kx]);
                    r.addr = oc * OSZ * OSZ + oy * OSZ + ox;
                    r.data = requant(sum);
                    exp_q.push_back(r);
                end
    endtask

    function automatic longint activity();
        return longint'(|{bus.conv_busy, bus.conv_done, bus.input_bram_ena, bus.weights_bram_ena,
                          bus.result_bram_ena, bus.result_bram_wea, bus.input_bram_addra,
                          bus.weights_bram_addra, bus.result_bram_addra, bus.result_bram_dina});
    endfunction

    // Called just after the edge that sampled conv_en; counts edges from it (inclusive) to DONE.
    task automatic wait_done(input int pulse_at, output int edges);
        edges = 1;
        while (edges <= RUN_CYCLES + 20) begin
            @(negedge clk);
            if (pulse_at > 0) bus.conv_en = (edges == pulse_at);
            if (bus.conv_done) return;
            @(posedge clk);
            edges++;
        end
        edges = -1;
    endtask

    task automatic run_conv(input int pattern, input int pulse_at, input bit hold);
        int edges;
        load_pattern(pattern);
        push_expected();
        rd_count = 0;
        bad_reads = 0;
        second_pixel_addr = -1;
        @(negedge clk);
        bus.conv_en = 1'b1;
        @(posedge clk);
        if (!hold) #1 bus.conv_en = 1'b0;
        wait_done(pulse_at, edges);
        check("done_latency", edges, RUN_CYCLES);
        check("busy_at_done", bus.conv_busy, 1);
        check("unreachable_reads", bad_reads, 0);
        check("pixel01_first_input_addr", second_pixel_addr, STR);
        check("results_pending_at_done", exp_q.size(), 0);
        if (hold) begin
            push_expected();
            @(negedge clk);
            check("idle_after_done", bus.conv_busy, 0);
            @(posedge clk);
            #1 bus.conv_en = 1'b0;
            wait_done(0, edges);
            check("restart_latency", edges, RUN_CYCLES);
            check("restart_results_pending", exp_q.size(), 0);
        end
        @(negedge clk);
        check("busy_clear", bus.conv_busy, 0);
    endtask

    task automatic reset_mid_run();
        load_pattern(4);
        push_expected();
        @(negedge clk);
        bus.conv_en = 1'b1;
        @(posedge clk);
        #1 bus.conv_en = 1'b0;
        repeat (70) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrun_reset_outputs", activity(), 0);
        check("midrun_reset_busy", bus.conv_busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("held_reset_outputs", activity(), 0);
        rstn = 1'b1;
    endtask

    initial begin
        bus.conv_en = 1'b0;
        #1 rstn = 1'b0;
        #11;
        check("reset_outputs", activity(), 0);
        @(negedge clk);
        rstn = 1'b1;
        run_conv(0, 0, 1'b0);
        run_conv(1, 0, 1'b0);
        run_conv(2, 0, 1'b0);
        run_conv(3, 0, 1'b0);
        run_conv(4, 57, 1'b0);
        reset_mid_run();
        run_conv(5, 0, 1'b0);
        run_conv(4, 0, 1'b1);
        run_conv(5, 33, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
